// File: rtl/div_arbiter_pkg.sv
// rtl/div_arbiter_pkg.sv - shared constants, tag layout and round-robin helper for div_arbiter
package div_arbiter_pkg;

    localparam int N_REQ       = 4;
    localparam int DW          = 20;
    localparam int DIV_LATENCY = 24;
    localparam int ID_W        = $clog2(N_REQ);
    localparam int PIPE_DEPTH  = DIV_LATENCY + 1;

    typedef struct packed {
        logic            valid;
        logic            dz;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        return (int'(id) == N_REQ - 1) ? '0 : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - requester-side request/response bundle for div_arbiter
interface div_arbiter_if;
    import div_arbiter_pkg::*;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_dividend;
    logic [N_REQ*DW-1:0] req_divisor;
    logic [N_REQ-1:0]    resp_valid;
    logic [DW-1:0]       resp_quotient;
    logic [DW-1:0]       resp_fractional;
    logic                resp_dz;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, resp_valid, resp_quotient, resp_fractional, resp_dz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, resp_valid, resp_quotient, resp_fractional, resp_dz
    );

endinterface

// File: rtl/div_arbiter_tag_pipe.sv
// rtl/div_arbiter_tag_pipe.sv - free-running tag shift register with async clear and any-valid flag
module div_arbiter_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 1,
    parameter int VBIT  = W - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_head,
    output logic         o_any_valid
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) o_any_valid = o_any_valid | r_stage[k][VBIT];
    end

    assign o_head = r_stage[DEPTH-1];

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one pipelined divider; optional DIV_ZERO_DETECT_EN
module div_arbiter
    import div_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    div_arbiter_if.slave  bus,
    input  logic          i_div_rfd,
    output logic [DW-1:0] o_div_dividend,
    output logic [DW-1:0] o_div_divisor,
    input  logic [DW-1:0] i_div_quotient,
    input  logic [DW-1:0] i_div_fractional,
    output logic          o_busy
);

    logic [ID_W-1:0] r_rr_ptr;
    logic [DW-1:0]   r_div_dividend;
    logic [DW-1:0]   r_div_divisor;
    logic            w_found;
    logic [ID_W-1:0] w_sel;
    logic [DW-1:0]   w_sel_dividend;
    logic [DW-1:0]   w_sel_divisor;
    logic            w_dz_in;
    tag_t            w_tag_in;
    tag_t            w_head;

    // Search order starts at r_rr_ptr and wraps; no grant while the divider is not ready.
    always_comb begin : grant_search
        logic [ID_W:0] v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        v_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (v_idx >= (ID_W+1)'(N_REQ)) v_idx = v_idx - (ID_W+1)'(N_REQ);
            if (!w_found && i_div_rfd && bus.req_valid[v_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_idx[ID_W-1:0];
            end
        end
        bus.req_ready = w_found ? (N_REQ'(1) << w_sel) : '0;
    end

    assign w_sel_dividend = bus.req_dividend[w_sel*DW +: DW];
    assign w_sel_divisor  = bus.req_divisor[w_sel*DW +: DW];

`ifdef DIV_ZERO_DETECT_EN
    assign w_dz_in = (w_sel_divisor == '0);
`else
    assign w_dz_in = 1'b0;
`endif

    assign w_tag_in = '{valid: w_found, dz: w_dz_in, id: w_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
        end else if (w_found) begin
            r_div_dividend <= w_sel_dividend;
            r_div_divisor  <= w_sel_divisor;
            r_rr_ptr       <= rr_next(w_sel);
        end
    end

    assign o_div_dividend = r_div_dividend;
    assign o_div_divisor  = r_div_divisor;

    div_arbiter_tag_pipe #(
        .DEPTH (PIPE_DEPTH),
        .W     (TAG_W),
        .VBIT  (TAG_W - 1)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_d         (w_tag_in),
        .o_head      (w_head),
        .o_any_valid (o_busy)
    );

    always_comb begin
        bus.resp_valid      = '0;
        bus.resp_quotient   = '0;
        bus.resp_fractional = '0;
        bus.resp_dz         = 1'b0;
        if (w_head.valid) begin
            bus.resp_valid = N_REQ'(1) << w_head.id;
`ifdef DIV_ZERO_DETECT_EN
            if (w_head.dz) begin
                bus.resp_quotient   = '1;
                bus.resp_fractional = '0;
                bus.resp_dz         = 1'b1;
            end else begin
                bus.resp_quotient   = i_div_quotient;
                bus.resp_fractional = i_div_fractional;
            end
`else
            bus.resp_quotient   = i_div_quotient;
            bus.resp_fractional = i_div_fractional;
`endif
        end
    end

`ifndef DIV_ZERO_DETECT_EN
    logic w_unused_dz;
    assign w_unused_dz = w_head.dz;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - scoreboard bench for div_arbiter with a behavioural 24-cycle divider
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          div_rfd;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic [DW-1:0] div_quotient;
    logic [DW-1:0] div_fractional;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stepn    = 0;
    bit ops_hold = 1'b0;

    typedef struct {
        int            id;
        logic [DW-1:0] q;
        logic [DW-1:0] f;
        logic          dz;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    div_arbiter_if bus();

    div_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .i_div_rfd        (div_rfd),
        .o_div_dividend   (div_dividend),
        .o_div_divisor    (div_divisor),
        .i_div_quotient   (div_quotient),
        .i_div_fractional (div_fractional),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*DW-1:0] model_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (b == '0) return {20'hABCDE, 20'h12345};
        return {a / b, a % b};
    endfunction

    logic [2*DW-1:0] dpipe [DIV_LATENCY];
    always @(posedge clk) begin
        dpipe[0] <= model_div(div_dividend, div_divisor);
        for (int k = 1; k < DIV_LATENCY; k++) dpipe[k] <= dpipe[k-1];
    end
    assign div_quotient   = dpipe[DIV_LATENCY-1][2*DW-1:DW];
    assign div_fractional = dpipe[DIV_LATENCY-1][DW-1:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Expected response recorded at the moment of accept
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (bus.req_valid[k] && bus.req_ready[k]) begin
                    exp_t e;
                    logic [DW-1:0]   a;
                    logic [DW-1:0]   b;
                    logic [2*DW-1:0] r;
                    a = bus.req_dividend[k*DW +: DW];
                    b = bus.req_divisor[k*DW +: DW];
                    r = model_div(a, b);
                    e.id  = k;
                    e.q   = r[2*DW-1:DW];
                    e.f   = r[DW-1:0];
                    e.dz  = 1'b0;
                    e.cyc = cyc;
`ifdef DIV_ZERO_DETECT_EN
                    if (b == '0) begin
                        e.q  = 20'hFFFFF;
                        e.f  = '0;
                        e.dz = 1'b1;
                    end
`endif
                    sb.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.resp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(bus.resp_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_onehot",    32'(bus.resp_valid),      32'(1) << e.id);
                chk("resp_quotient",  32'(bus.resp_quotient),   32'(e.q));
                chk("resp_fractional",32'(bus.resp_fractional), 32'(e.f));
                chk("resp_dz",        32'(bus.resp_dz),         32'(e.dz));
                chk("resp_latency",   32'(cyc - e.cyc),         32'd25);
            end
        end
    end

    task automatic default_ops();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_dividend[i*DW +: DW] = DW'(1000 * (i + 1) + 13 * stepn);
            bus.req_divisor[i*DW +: DW]  = DW'(i + 2 + (stepn % 5));
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy, input string name);
        if (!ops_hold) default_ops();
        bus.req_valid = v;
        @(negedge clk);
        chk(name, 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        stepn++;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        div_rfd       = 1'b1;
        bus.req_valid = '0;
        default_ops();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_busy",       32'(busy),           32'h0);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("reset_dividend",   32'(div_dividend),   32'h0);
        chk("reset_ready",      32'(bus.req_ready),  32'h0);
        rst_n = 1'b1;

        // All four requesters from reset: strict rotation from id 0
        for (int i = 0; i < 8; i++) step(4'hF, 4'(1 << (i % 4)), "t2_grant");
        idle(30);

        ops_hold = 1'b1;
        bus.req_dividend[0 +: DW] = 20'd100;
        bus.req_divisor[0 +: DW]  = 20'd3;
        step(4'b0001, 4'b0001, "t1_grant");
        ops_hold = 1'b0;
        idle(30);

        // Pointer now 1; one grant to 1 moves it to 2
        step(4'b0010, 4'b0010, "t3_pre");
        step(4'b1010, 4'b1000, "t3_grant3");
        step(4'b1010, 4'b0010, "t3_grant1");
        step(4'b1111, 4'b0100, "t3_rr_at_2");

        step(4'hF, 4'b1000, "t4_grant");
        step(4'hF, 4'b0001, "t4_grant");
        step(4'hF, 4'b0010, "t4_grant");
        div_rfd = 1'b0;
        repeat (5) step(4'hF, 4'b0000, "t4_rfd_low");
        div_rfd = 1'b1;
        step(4'hF, 4'b0100, "t4_resume");
        step(4'hF, 4'b1000, "t4_resume");
        step(4'hF, 4'b0001, "t4_resume");
        step(4'hF, 4'b0010, "t4_resume");

        ops_hold = 1'b1;
        bus.req_dividend[2*DW +: DW] = 20'd12345;
        bus.req_divisor[2*DW +: DW]  = 20'd0;
        step(4'b0100, 4'b0100, "t6_grant");
        ops_hold = 1'b0;
        idle(35);
        chk("drain_busy",  32'(busy),      32'h0);
        chk("drain_empty", 32'(sb.size()), 32'h0);

        for (int i = 0; i < 10; i++) step(4'hF, 4'(1 << ((3 + i) % 4)), "t5_grant");
        bus.req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_reset_busy",     32'(busy),           32'h0);
        chk("t5_reset_resp",     32'(bus.resp_valid), 32'h0);
        chk("t5_reset_dividend", 32'(div_dividend),   32'h0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(40);
        chk("t5_after_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
